// File: rtl/monitor_bus_host_if.sv
// Command handshake, response, interrupt and slot-bus signals of the BKM-68X host.
// master = the host block; slave = the command source plus the slot card.
interface monitor_bus_host_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       bus_reset_req;
    logic       irq_pending;
    logic       irq_ack;
    logic       busy;
    logic       slot_x_int_x;
    logic       clk_rw;
    logic       ax_d;
    logic       r_wx;
    logic       bus_reset_x;
    logic [7:0] ad_out;
    logic       ad_oe_x;
    logic [7:0] ad_in;
    logic       int_x;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, bus_reset_req, irq_ack, ad_in, int_x,
        output cmd_ready, rsp_valid, rsp_rdata, irq_pending, busy,
        output slot_x_int_x, clk_rw, ax_d, r_wx, bus_reset_x, ad_out, ad_oe_x
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, bus_reset_req, irq_ack, ad_in, int_x,
        input  cmd_ready, rsp_valid, rsp_rdata, irq_pending, busy,
        input  slot_x_int_x, clk_rw, ax_d, r_wx, bus_reset_x, ad_out, ad_oe_x
    );
endinterface

// File: rtl/monitor_bus_host.sv
// Monitor-side initiator for the BKM-68X slot: one command -> address phase + data phase.
// Latency 2*(SETUP+STROBE+HOLD)+1 cycles accept-to-rsp_valid; cmd_ready low while busy or a bus reset is pending.
module monitor_bus_host #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2,
    parameter int RESET_CYCLES  = 16
) (
    input logic                clk_50mhz_in,
    input logic                reset_x,
    monitor_bus_host_if.master bus
);
    localparam logic [2:0] ST_RESET_BUS = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_A_SETUP   = 3'd2;
    localparam logic [2:0] ST_A_STROBE  = 3'd3;
    localparam logic [2:0] ST_A_HOLD    = 3'd4;
    localparam logic [2:0] ST_D_SETUP   = 3'd5;
    localparam logic [2:0] ST_D_STROBE  = 3'd6;
    localparam logic [2:0] ST_D_HOLD    = 3'd7;

    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] RESET_LD  = 8'(RESET_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       write_q, write_d;
    logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
    logic       pend_q, pend_d;
    logic       slot_q, slot_d, clk_rw_q, clk_rw_d, ax_d_q, ax_d_d, r_wx_q, r_wx_d;
    logic       oe_q, oe_d, brx_q, brx_d;
    logic [7:0] ad_out_q, ad_out_d, rdata_q, rdata_d;
    logic       rsp_q, rsp_d;
    logic       sync1_q, sync2_q, sync3_q, irq_q, irq_d;
    logic       last, accept, enter_rst, fall;

    assign last      = (cnt_q == 8'd0);
    assign accept    = (state_q == ST_IDLE) && !pend_q && bus.cmd_valid;
    assign enter_rst = (state_d == ST_RESET_BUS) && (state_q != ST_RESET_BUS);

    always_comb begin
        state_d = state_q;
        cnt_d   = last ? 8'd0 : cnt_q - 8'd1;
        case (state_q)
            ST_RESET_BUS: if (last) state_d = ST_IDLE;
            ST_IDLE: begin
                // A pending bus reset outranks a waiting command
                if (pend_q) begin
                    state_d = ST_RESET_BUS;
                    cnt_d   = RESET_LD;
                end else if (bus.cmd_valid) begin
                    state_d = ST_A_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            ST_A_SETUP:  if (last) begin state_d = ST_A_STROBE; cnt_d = STROBE_LD; end
            ST_A_STROBE: if (last) begin state_d = ST_A_HOLD;   cnt_d = HOLD_LD;   end
            ST_A_HOLD:   if (last) begin state_d = ST_D_SETUP;  cnt_d = SETUP_LD;  end
            ST_D_SETUP:  if (last) begin state_d = ST_D_STROBE; cnt_d = STROBE_LD; end
            ST_D_STROBE: if (last) begin state_d = ST_D_HOLD;   cnt_d = HOLD_LD;   end
            ST_D_HOLD:   if (last) state_d = ST_IDLE;
            default:     state_d = ST_RESET_BUS;
        endcase
    end

    assign write_d = accept ? bus.cmd_write : write_q;
    assign addr_d  = accept ? bus.cmd_addr  : addr_q;
    assign wdata_d = accept ? bus.cmd_wdata : wdata_q;

    // Bus pins are decoded from the next state so they change on the state edge itself
    always_comb begin
        slot_d   = 1'b1;
        clk_rw_d = 1'b1;
        ax_d_d   = 1'b1;
        r_wx_d   = 1'b1;
        oe_d     = 1'b1;
        brx_d    = 1'b1;
        ad_out_d = ad_out_q;
        case (state_d)
            ST_RESET_BUS: brx_d = 1'b0;
            ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
                slot_d   = 1'b0;
                ax_d_d   = 1'b0;
                r_wx_d   = 1'b0;
                oe_d     = 1'b0;
                ad_out_d = addr_d;
                clk_rw_d = (state_d != ST_A_STROBE);
            end
            ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
                slot_d   = 1'b0;
                r_wx_d   = ~write_d;
                clk_rw_d = (state_d != ST_D_STROBE);
                if (write_d) begin
                    oe_d     = 1'b0;
                    ad_out_d = wdata_d;
                end
            end
            default: ;
        endcase
    end

    assign rsp_d   = (state_q == ST_D_HOLD) && last;
    assign rdata_d = ((state_q == ST_D_STROBE) && last && !write_q) ? bus.ad_in : rdata_q;
    assign pend_d  = bus.bus_reset_req | (pend_q & ~enter_rst);

    // Only a fresh synchronised falling edge sets the latch; it beats a same-cycle ack
    assign fall  = sync3_q & ~sync2_q;
    assign irq_d = (state_q == ST_RESET_BUS) ? 1'b0 :
                   fall                      ? 1'b1 :
                   bus.irq_ack               ? 1'b0 : irq_q;

    always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
        if (!reset_x) begin
            state_q  <= ST_RESET_BUS;
            cnt_q    <= RESET_LD;
            write_q  <= 1'b0;
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            pend_q   <= 1'b0;
            slot_q   <= 1'b1;
            clk_rw_q <= 1'b1;
            ax_d_q   <= 1'b1;
            r_wx_q   <= 1'b1;
            oe_q     <= 1'b1;
            brx_q    <= 1'b0;
            ad_out_q <= 8'h00;
            rdata_q  <= 8'h00;
            rsp_q    <= 1'b0;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            sync3_q  <= 1'b1;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            pend_q   <= pend_d;
            slot_q   <= slot_d;
            clk_rw_q <= clk_rw_d;
            ax_d_q   <= ax_d_d;
            r_wx_q   <= r_wx_d;
            oe_q     <= oe_d;
            brx_q    <= brx_d;
            ad_out_q <= ad_out_d;
            rdata_q  <= rdata_d;
            rsp_q    <= rsp_d;
            sync1_q  <= bus.int_x;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            irq_q    <= irq_d;
        end
    end

    assign bus.cmd_ready    = (state_q == ST_IDLE) && !pend_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.rsp_valid    = rsp_q;
    assign bus.rsp_rdata    = rdata_q;
    assign bus.irq_pending  = irq_q;
    assign bus.slot_x_int_x = slot_q;
    assign bus.clk_rw       = clk_rw_q;
    assign bus.ax_d         = ax_d_q;
    assign bus.r_wx         = r_wx_q;
    assign bus.bus_reset_x  = brx_q;
    assign bus.ad_out       = ad_out_q;
    assign bus.ad_oe_x      = oe_q;
endmodule

// File: tb/tb_monitor_bus_host.sv
// Bench for monitor_bus_host: directed and random commands, deferred bus reset, interrupt latch.
module tb_monitor_bus_host;
    localparam int S   = 2;
    localparam int T   = 4;
    localparam int H   = 2;
    localparam int RST = 16;
    localparam int P   = S + T + H;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    monitor_bus_host_if bus();

    monitor_bus_host #(
        .SETUP_CYCLES (S),
        .STROBE_CYCLES(T),
        .HOLD_CYCLES  (H),
        .RESET_CYCLES (RST)
    ) dut (
        .clk_50mhz_in(clk),
        .reset_x     (rst_n),
        .bus         (bus)
    );

    bit         c_w [16];
    logic [7:0] c_a [16];
    logic [7:0] c_d [16];
    logic [7:0] c_r [16];
    logic [7:0] m_rdata = 8'h00;
    bit         m_pend  = 1'b0;
    bit         m_irq   = 1'b0;
    bit   [2:0] ih      = 3'b111;
    int         req_k   = 0;

    localparam logic [16:0] RESET_VEC = {1'b0, 1'b1, 1'b0, 1'b0, 5'b11111, 8'h00};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] obs();
        return {bus.cmd_ready, bus.busy, bus.rsp_valid, bus.bus_reset_x, bus.slot_x_int_x,
                bus.clk_rw, bus.ax_d, bus.r_wx, bus.ad_oe_x, bus.ad_out};
    endfunction

    function automatic bit strobe_at(input int k);
        int off;
        off = (k - 1) % P;
        return (off >= S) && (off < S + T);
    endfunction

    // Expected pins in cycle k (1..2P) after the accept edge
    function automatic logic [16:0] exp_bus(input int k, input bit w, input logic [7:0] a, input logic [7:0] d);
        bit dph;
        dph = ((k - 1) / P) == 1;
        return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ~strobe_at(k), dph, dph ? ~w : 1'b0,
                dph & ~w, (dph && w) ? d : a};
    endfunction

    task automatic load(input int i);
        bus.cmd_write = c_w[i];
        bus.cmd_addr  = c_a[i];
        bus.cmd_wdata = c_d[i];
    endtask

    task automatic reset_pulse_check();
        int n;
        n = 0;
        while (bus.bus_reset_x == 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("rst_len", n, RST);
        chk("rst_rdy", 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic run_cmds(input int n, input bit b2b);
        bit more;
        int w;
        load(0);
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            more = b2b && (i + 1 < n);
            w = 0;
            while (!bus.cmd_ready && w < 200) begin
                @(negedge clk);
                w++;
            end
            chk("accept", 32'(bus.cmd_ready), 32'd1);
            if (!bus.cmd_ready) begin
                bus.cmd_valid = 1'b0;
                return;
            end
            if (b2b && i > 0) chk("b2b_gap", w, 0);
            for (int k = 1; k <= 2 * P + 1; k++) begin
                @(negedge clk);
                if (k <= 2 * P) begin
                    chk($sformatf("bus_k%0d", k), 32'(obs()), 32'(exp_bus(k, c_w[i], c_a[i], c_d[i])));
                end else begin
                    if (!c_w[i]) m_rdata = c_r[i];
                    chk("rsp", 32'(obs()),
                        32'({~m_pend, 1'b0, 1'b1, 1'b1, 5'b11111, c_w[i] ? c_d[i] : c_a[i]}));
                    chk("rdata", 32'(bus.rsp_rdata), 32'(m_rdata));
                end
                if (k == 1) begin
                    if (more) load(i + 1);
                    else bus.cmd_valid = 1'b0;
                end
                bus.ad_in = (!c_w[i] && k > P && strobe_at(k)) ? c_r[i] : 8'hFF;
                bus.bus_reset_req = (k == req_k);
                if (k == req_k) m_pend = 1'b1;
                if (k == 2 * P + 1 && m_pend && !more) bus.cmd_valid = 1'b1;
            end
            if (!more) begin
                @(negedge clk);
                bus.cmd_valid = 1'b0;
                chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
                if (m_pend) begin
                    chk("defer_noacc", 32'({bus.slot_x_int_x, bus.busy, bus.bus_reset_x}), 32'b110);
                    m_pend = 1'b0;
                    reset_pulse_check();
                end
                if (i + 1 < n) begin
                    load(i + 1);
                    bus.cmd_valid = 1'b1;
                end
            end
        end
    endtask

    // Called at a negedge: checks this cycle's latch, then drives int_x/irq_ack for the cycle
    task automatic irq_cycle(input bit iv, input bit ack);
        bit fall;
        chk("irq", 32'(bus.irq_pending), 32'(m_irq));
        bus.int_x   = iv;
        bus.irq_ack = ack;
        fall  = ih[2] & ~ih[1];
        m_irq = fall | (m_irq & ~ack);
        ih    = {ih[1:0], iv};
        @(negedge clk);
    endtask

    task automatic rand_cmds(input int n);
        for (int i = 0; i < n; i++) begin
            c_w[i] = 1'($urandom_range(0, 1));
            c_a[i] = 8'($urandom);
            c_d[i] = 8'($urandom);
            c_r[i] = 8'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit iv;
        rst_n             = 1'b0;
        bus.cmd_valid     = 1'b0;
        bus.cmd_write     = 1'b0;
        bus.cmd_addr      = 8'h00;
        bus.cmd_wdata     = 8'h00;
        bus.bus_reset_req = 1'b0;
        bus.irq_ack       = 1'b0;
        bus.ad_in         = 8'hFF;
        bus.int_x         = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_vec", 32'(obs()), 32'(RESET_VEC));
        chk("reset_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("reset_irq", 32'(bus.irq_pending), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        reset_pulse_check();
        chk("idle_bus", 32'(obs()), 32'({1'b1, 1'b0, 1'b0, 1'b1, 5'b11111, 8'h00}));

        c_w[0] = 1'b1; c_a[0] = 8'h21; c_d[0] = 8'h5A; c_r[0] = 8'h00;
        run_cmds(1, 1'b0);
        c_w[0] = 1'b0; c_a[0] = 8'h10; c_d[0] = 8'h77; c_r[0] = 8'hC3;
        run_cmds(1, 1'b0);

        rand_cmds(5);
        c_w[0] = 1'b1;
        c_w[1] = 1'b0;
        run_cmds(5, 1'b1);

        req_k = 4;
        c_w[0] = 1'b1; c_a[0] = 8'h3C; c_d[0] = 8'h96;
        run_cmds(1, 1'b0);
        req_k = 0;

        rand_cmds(10);
        run_cmds(10, 1'b0);

        // Interrupt: sustained low, ack, then an ack landing on a new edge
        repeat (3) irq_cycle(1'b1, 1'b0);
        repeat (6) irq_cycle(1'b0, 1'b0);
        irq_cycle(1'b0, 1'b1);
        repeat (5) irq_cycle(1'b0, 1'b0);
        repeat (4) irq_cycle(1'b1, 1'b0);
        repeat (2) irq_cycle(1'b0, 1'b0);
        irq_cycle(1'b0, 1'b1);
        repeat (2) irq_cycle(1'b0, 1'b0);
        iv = 1'b0;
        for (int c = 0; c < 150; c++) begin
            if ($urandom_range(0, 3) == 0) iv = ~iv;
            irq_cycle(iv, $urandom_range(0, 4) == 0);
        end
        repeat (4) irq_cycle(1'b1, 1'b1);
        chk("irq_last", 32'(bus.irq_pending), 32'(m_irq));
        bus.irq_ack = 1'b0;

        // Reset asserted in the middle of a transaction
        c_w[0] = 1'b1; c_a[0] = 8'h44; c_d[0] = 8'hEE;
        load(0);
        bus.cmd_valid = 1'b1;
        for (int w = 0; w < 50 && !bus.cmd_ready; w++) @(negedge clk);
        chk("mid_accept", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_vec", 32'(obs()), 32'(RESET_VEC));
        chk("mid_reset_rdata", 32'(bus.rsp_rdata), 32'd0);
        m_rdata = 8'h00;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        reset_pulse_check();
        c_w[0] = 1'b0; c_a[0] = 8'h5F; c_d[0] = 8'h00; c_r[0] = 8'h3E;
        run_cmds(1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
